// File: rtl/axis_i2s_pkg.sv
// Shared types and width helpers for the AXI-Stream to I2S transmitter.
package axis_i2s_pkg;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_i2s_tx_if.sv
// AXI-Stream sample channel feeding the I2S transmitter.
interface axis_i2s_tx_if #(
    parameter int unsigned DW = 24
) ();

    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/i2s_clkgen.sv
// SCK divider: toggles i2s_sck every CLK_DIV clk cycles and flags the falling edge.
module i2s_clkgen
    import axis_i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_sck,
    output logic o_fall_stb
);

    localparam int unsigned DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap     = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    // Same-cycle strobe so the top updates WS/SD on the very edge SCK falls.
    assign o_fall_stb = w_wrap & r_sck;
    assign o_sck      = r_sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/axis_i2s_tx.sv
// AXI-Stream sink that serializes stereo sample pairs onto an I2S master transmit link.
module axis_i2s_tx
    import axis_i2s_pkg::*;
#(
    parameter int unsigned DW      = 24,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    axis_i2s_tx_if.slave  s_axis,
    output logic          i2s_sck,
    output logic          i2s_ws,
    output logic          i2s_sd,
    output logic          underflow,
    output logic          sync_err
);

    localparam int unsigned IDX_W = cnt_w(DW);

    logic [DW-1:0]    r_hold_data;
    logic             r_hold_last;
    logic             r_hold_valid;
    logic [IDX_W-1:0] r_idx;
    i2s_ch_t          r_ch;
    i2s_ch_t          r_ws;
    logic [DW-1:0]    r_shift;
    logic             r_underflow;
    logic             r_sync_err;

    logic             w_fall_stb;
    logic             w_load;
    logic             w_misalign;
    logic             w_take;
    i2s_ch_t          w_next_ch;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .rst        (rst),
        .o_sck      (i2s_sck),
        .o_fall_stb (w_fall_stb)
    );

    assign w_next_ch  = (r_ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    assign w_load     = w_fall_stb && (r_idx == IDX_W'(DW - 1));
    // A right-channel sample waiting at a left slot is held back for the right slot.
    assign w_misalign = r_hold_valid && r_hold_last && (w_next_ch == CH_LEFT);
    assign w_take     = w_load && r_hold_valid && !w_misalign;

    assign s_axis.tready = !r_hold_valid;
    assign i2s_ws        = r_ws;
    assign i2s_sd        = r_shift[DW-1];
    assign underflow     = r_underflow;
    assign sync_err      = r_sync_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_idx        <= IDX_W'(DW - 1);
            r_ch         <= CH_RIGHT;
            r_ws         <= CH_LEFT;
            r_shift      <= '0;
            r_underflow  <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            if (w_take) begin
                r_hold_valid <= 1'b0;
            end else if (s_axis.tvalid && !r_hold_valid) begin
                r_hold_data  <= s_axis.tdata;
                r_hold_last  <= s_axis.tlast;
                r_hold_valid <= 1'b1;
            end

            if (w_fall_stb) begin
                if (w_load) begin
                    r_idx   <= '0;
                    r_ch    <= w_next_ch;
                    r_shift <= w_take ? r_hold_data : '0;
                end else begin
                    r_idx   <= r_idx + IDX_W'(1);
                    r_shift <= {r_shift[DW-2:0], 1'b0};
                end
                // WS leads the slot by one bit.
                if (r_idx == IDX_W'(DW - 2)) begin
                    r_ws <= w_next_ch;
                end
            end

            r_underflow <= w_load && !r_hold_valid;
            r_sync_err  <= w_load && w_misalign;
        end
    end

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Randomized self-checking bench: slot-level reference model plus an I2S receiver scoreboard.
module tb_axis_i2s_tx;

    localparam int unsigned DW      = 8;
    localparam int unsigned CLK_DIV = 2;
    localparam int SCKP  = 2 * CLK_DIV;
    localparam int FIRST = 2 * CLK_DIV;
    localparam int SLOT  = DW * SCKP;
    localparam int WS0   = FIRST + (DW - 1) * SCKP;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck, ws, sd, uf, se;

    axis_i2s_tx_if #(.DW(DW)) s_axis_if ();

    axis_i2s_tx #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_axis_if),
        .i2s_sck   (sck),
        .i2s_ws    (ws),
        .i2s_sd    (sd),
        .underflow (uf),
        .sync_err  (se)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int gap_cnt  = 0;
    int gap_max  = 0;
    smp_t          src_q[$];
    smp_t          model_q[$];
    smp_t          sent_q[$];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] cur;
    logic [DW-1:0] rx_word;
    int            rx_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic clear_state();
        t       = 0;
        gap_cnt = 0;
        cur     = '0;
        rx_word = '0;
        rx_bits = 0;
        src_q.delete();
        model_q.delete();
        sent_q.delete();
        rx_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sck", 32'(sck), 0);
        check("rst_ws", 32'(ws), 0);
        check("rst_sd", 32'(sd), 0);
        check("rst_tready", 32'(s_axis_if.tready), 1);
        check("rst_underflow", 32'(uf), 0);
        check("rst_sync_err", 32'(se), 0);
        rst = 1'b0;
        clear_state();
    endtask

    task automatic tick();
        logic fire;
        logic exp_uf, exp_se, exp_ws, exp_sd;
        int   slot;
        s_axis_if.tvalid = (src_q.size() != 0) && (gap_cnt == 0);
        if (s_axis_if.tvalid) begin
            s_axis_if.tdata = src_q[0].data;
            s_axis_if.tlast = src_q[0].last;
        end
        fire = s_axis_if.tvalid && s_axis_if.tready;
        @(posedge clk);
        #1;
        t++;
        exp_uf = 1'b0;
        exp_se = 1'b0;
        // Slot-level rules: each slot start takes the oldest accepted sample unless starved or misaligned.
        if (t >= FIRST && (t - FIRST) % SLOT == 0) begin
            slot = (t - FIRST) / SLOT;
            if (model_q.size() == 0) begin
                cur = '0;
                exp_uf = 1'b1;
            end else if (slot % 2 == 0 && model_q[0].last) begin
                cur = '0;
                exp_se = 1'b1;
            end else begin
                cur = model_q.pop_front().data;
            end
        end
        if (fire) begin
            model_q.push_back(src_q[0]);
            sent_q.push_back(src_q[0]);
            void'(src_q.pop_front());
            gap_cnt = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
        end
        exp_ws = (t < WS0) ? 1'b0 : 1'((((t - WS0) / SLOT) + 1) % 2);
        exp_sd = (t < FIRST) ? 1'b0 : cur[DW - 1 - ((t - FIRST) % SLOT) / SCKP];
        check("sck", 32'(sck), 32'((t / CLK_DIV) % 2));
        check("ws", 32'(ws), 32'(exp_ws));
        check("sd", 32'(sd), 32'(exp_sd));
        check("tready", 32'(s_axis_if.tready), 32'(model_q.size() == 0));
        check("underflow", 32'(uf), 32'(exp_uf));
        check("sync_err", 32'(se), 32'(exp_se));
        // Receiver view: sample SD on each SCK rise once framing has started.
        if (t >= FIRST && (t - FIRST) % SCKP == CLK_DIV) begin
            rx_word = {rx_word[DW-2:0], sd};
            rx_bits++;
            if (rx_bits == DW) begin
                rx_q.push_back(rx_word);
                rx_bits = 0;
            end
        end
    endtask

    task automatic run_until(input int tend);
        while (t < tend) tick();
    endtask

    task automatic push_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back({DW'($urandom), 1'b0});
            src_q.push_back({DW'($urandom), 1'b1});
        end
    endtask

    task automatic check_rx(input string tag, input int n);
        check({tag, "_nwords"}, 32'(rx_q.size() >= n), 1);
        for (int k = 0; k < n; k++) begin
            if (k < rx_q.size() && k < sent_q.size()) begin
                check(tag, 32'(rx_q[k]), 32'(sent_q[k].data));
            end else begin
                check({tag, "_missing"}, 0, 1);
            end
        end
    endtask

    initial begin
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        s_axis_if.tlast  = 1'b0;

        // Pre-streamed pair, then 4 random pairs with short gaps.
        do_reset();
        gap_max = 20;
        src_q.push_back({8'hA5, 1'b0});
        src_q.push_back({8'h3C, 1'b1});
        push_pairs(4);
        run_until(FIRST + SLOT * 11);
        check("a_accepted", 32'(sent_q.size()), 10);
        check_rx("a_word", 10);

        // Starved link: zeros and one underflow per slot.
        do_reset();
        gap_max = 0;
        run_until(FIRST + SLOT * 4 + 2);

        // Right sample first: realigned into the right slot.
        do_reset();
        src_q.push_back({8'h11, 1'b1});
        src_q.push_back({8'h22, 1'b0});
        src_q.push_back({8'h33, 1'b1});
        run_until(FIRST + SLOT * 4 + 1);
        check("c_nwords", 32'(rx_q.size() >= 4), 1);
        if (rx_q.size() >= 4) begin
            check("c_w0", 32'(rx_q[0]), 32'h00);
            check("c_w1", 32'(rx_q[1]), 32'h11);
            check("c_w2", 32'(rx_q[2]), 32'h22);
            check("c_w3", 32'(rx_q[3]), 32'h33);
        end

        // Asynchronous reset in the right slot at bit 4, with a sample held.
        do_reset();
        src_q.push_back({8'hF0, 1'b0});
        src_q.push_back({8'h0F, 1'b1});
        src_q.push_back({8'hFF, 1'b0});
        run_until(FIRST + SLOT + 4 * SCKP + CLK_DIV);
        #1;
        rst = 1'b1;
        #1;
        check("d_sck", 32'(sck), 0);
        check("d_ws", 32'(ws), 0);
        check("d_sd", 32'(sd), 0);
        check("d_tready", 32'(s_axis_if.tready), 1);
        do_reset();
        src_q.push_back({8'h5A, 1'b0});
        src_q.push_back({8'hC3, 1'b1});
        run_until(FIRST + SLOT * 2 + 1);
        check_rx("d_word", 2);

        // Constant tvalid: one sample per slot, nothing lost or repeated.
        do_reset();
        push_pairs(17);
        run_until(FIRST + SLOT * 16);
        check("e_accepted", 32'(sent_q.size()), 17);
        check_rx("e_word", 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_i2s_tx.md
# axis_i2s_tx

Consumes an AXI-Stream of audio samples and serializes them onto a standard I2S transmit link (SCK, WS, SD) as bus master. It is the sink end of the sample streams produced by the stream pipeline (skid buffers, filters): it drains one stereo sample pair per I2S frame, absorbs upstream jitter with a one-entry holding register, and reports underflow and channel-alignment errors.

## Interface
- DW, 24, sample width in bits; also the I2S slot width in SCK periods (DW >= 2)
- CLK_DIV, 4, clk cycles per SCK half-period (CLK_DIV >= 2)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- s_axis_tdata  input  DW  sample, two's complement, MSB transmitted first
- s_axis_tvalid  input  1  sample valid
- s_axis_tready  output  1  holding register empty
- s_axis_tlast  input  1  1 = right-channel sample (end of stereo pair)
- i2s_sck  output  1  bit clock
- i2s_ws  output  1  word select: 0 = left slot, 1 = right slot
- i2s_sd  output  1  serial data
- underflow  output  1  one-clk pulse: slot started with no sample available
- sync_err  output  1  one-clk pulse: tlast=1 sample met at a left-slot load

## Operation
- Holding register (hold_data, hold_last, hold_valid): s_axis_tready = !hold_valid; a transfer (tvalid && tready) loads it and sets hold_valid. It is cleared when consumed at a slot load. A load and a consume in the same cycle cannot occur because tready is low while hold_valid=1.
- SCK divider: div_cnt counts 0..CLK_DIV-1; when it reaches CLK_DIV-1 it wraps and i2s_sck toggles. Fall strobe = toggle while i2s_sck=1.
- Bit index idx (0..DW-1) increments mod DW on every fall strobe; ch (LEFT/RIGHT) is the slot currently being shifted.
- On the fall strobe where idx wraps to 0 (slot load):
  - Normal: the holding register is valid, and either hold_last=0 with the slot LEFT, or the slot RIGHT. The shift register loads hold_data, the hold is consumed, and i2s_sd = MSB.
  - Underflow: hold_valid=0. Transmit all zeros for the slot and pulse underflow.
  - Realignment: the slot is LEFT and hold_last=1. Transmit zeros in LEFT, do not consume, pulse sync_err. The held sample then goes out in the following RIGHT slot.
  - A RIGHT slot with hold_last=0 transmits normally; no error is flagged.
- On the other fall strobes, the shift register shifts left and i2s_sd = the next bit.
- On the fall strobe where idx becomes DW-1, i2s_ws is set to the next slot's channel. This gives the standard I2S one-bit WS lead.
- Channel alternates LEFT, RIGHT, LEFT, and so on, and is free-running; output never stalls.

## Timing
- Reset values: i2s_sck=0, i2s_ws=0, i2s_sd=0, s_axis_tready=1, underflow=0, sync_err=0.
- Reset internal state: div_cnt=0, idx=DW-1, ch=RIGHT (the next slot is LEFT), hold_valid=0, shift=0.
- First SCK rise is at clk edge CLK_DIV after reset release; the first fall (LEFT slot load) is at edge 2·CLK_DIV.
- SD and WS change only on SCK falling edges (registered, same clk edge as the SCK fall). The receiver samples on the rising edge.
- Frame is 2·DW SCK periods, i.e. 4·DW·CLK_DIV clk cycles.
- Stream-to-pin latency: MSB appears at the first slot load after the transfer, at least 1 clk later.
- underflow and sync_err are asserted in the clk cycle after the slot-load edge, for exactly 1 cycle.
- Reset mid-frame: all outputs return to reset values asynchronously and the held sample is dropped. Framing restarts with LEFT, as after power-up.

## Structure
- Package axis_i2s_pkg:
  - typedef enum logic {CH_LEFT=1'b0, CH_RIGHT=1'b1} i2s_ch_t, used as the encoding of i2s_ws.
  - Function clog2-based widths for div_cnt and idx.
- Sub-module i2s_clkgen (CLK_DIV): div_cnt and i2s_sck, exporting the fall_stb pulse. The top level holds the holding register, idx/ch, shifter and error pulses.

## Test plan
All scenarios use DW=8, CLK_DIV=2.
- Reset release with a pair pre-streamed: 0xA5 (tlast=0), 0x3C (tlast=1) -> WS low for 8 SCK, then high. SD = 10100101 then 00111100, each MSB 1 SCK after its WS edge; SCK period 4 clk.
- Continuous stream of 4 pairs with random tvalid gaps shorter than one slot -> bit-exact output, underflow never asserted, tready low while the hold is full.
- No stream input after reset -> SD=0 throughout; underflow pulses once per slot (every 32 clk); WS keeps toggling.
- Stream 0x11(tlast=1) first -> LEFT slot zeros with a sync_err pulse; RIGHT slot = 00010001; the next 0x22(0)/0x33(1) align normally.
- Assert rst mid-RIGHT slot at idx=4 -> sck/ws/sd go to 0 immediately with tready=1. After release, a new pair transmits starting in LEFT at edge 4.
- Hold tvalid=1 constantly -> exactly one sample is accepted per slot, no samples lost or duplicated (scoreboard across 16 slots).
